tdc_meas_ctrl: RTL

//  Measurement sequencer for the delay-line TDC (tdc, stop = clk). Each measurement:
//  - clears the line, launches a start edge and captures the thermometer result.
//  - converts the result to a bubble-tolerant count (popcount).

---
 rtl/tdc_meas_ctrl_if.sv | 30 +++
 rtl/tdc_meas_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl_if.sv
// Handshake and result bundle between the TDC measurement sequencer and its user.
// The sequencer takes the slave side; the pin wrapper or bench takes the master side.
interface tdc_meas_ctrl_if #(
  parameter int N_DELAY = 192,
  parameter int LOG_AVG = 4
);
  localparam int CNT_W = $clog2(N_DELAY + 1);

  logic                     i_go;
  logic                     i_abort;
  logic [N_DELAY-1:0]       i_result;
  logic                     o_start;
  logic                     o_busy;
  logic                     o_done;
  logic [CNT_W+LOG_AVG-1:0] o_sum;
  logic [CNT_W-1:0]         o_min;
  logic [CNT_W-1:0]         o_max;
  logic                     o_underrun;
  logic                     o_overrun;

  modport slave (
    input  i_go, i_abort, i_result,
    output o_start, o_busy, o_done, o_sum, o_min, o_max, o_underrun, o_overrun
  );

  modport master (
    output i_go, i_abort, i_result,
    input  o_start, o_busy, o_done, o_sum, o_min, o_max, o_underrun, o_overrun
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Burst sequencer for the delay-line TDC: clear, launch, capture, popcount and
// accumulate 2**LOG_AVG samples, then publish sum/min/max and range flags.
module tdc_meas_ctrl #(
  parameter int N_DELAY = 192,
  parameter int LOG_AVG = 4,
  parameter int CLR_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  tdc_meas_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(N_DELAY + 1);
  localparam int SUM_W = CNT_W + LOG_AVG;
  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FIRE,
    S_CAPT,
    S_ACC,
    S_DONE
  } state_e;

  state_e             state_q,     state_d;
  logic [CLR_W-1:0]   clr_cnt_q,   clr_cnt_d;
  logic [LOG_AVG-1:0] idx_q,       idx_d;
  logic [N_DELAY-1:0] res_q,       res_d;
  logic [SUM_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   run_min_q,   run_min_d;
  logic [CNT_W-1:0]   run_max_q,   run_max_d;
  logic               run_unf_q,   run_unf_d;
  logic               run_ovf_q,   run_ovf_d;
  logic               start_q,     start_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [SUM_W-1:0]   sum_q,       sum_d;
  logic [CNT_W-1:0]   min_q,       min_d;
  logic [CNT_W-1:0]   max_q,       max_d;
  logic               unf_q,       unf_d;
  logic               ovf_q,       ovf_d;

  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   min_nxt;
  logic [CNT_W-1:0]   max_nxt;
  logic               unf_nxt;
  logic               ovf_nxt;

  // Counting every one (not the thermometer edge position) makes bubbles harmless.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_DELAY-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    idx_d     = idx_q;
    res_d     = res_q;
    acc_d     = acc_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    run_unf_d = run_unf_q;
    run_ovf_d = run_ovf_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    unf_d     = unf_q;
    ovf_d     = ovf_q;

    cnt     = popcount(res_q);
    acc_nxt = acc_q + SUM_W'(cnt);
    min_nxt = (cnt < run_min_q) ? cnt : run_min_q;
    max_nxt = (cnt > run_max_q) ? cnt : run_max_q;
    unf_nxt = run_unf_q | (cnt == '0);
    ovf_nxt = run_ovf_q | (cnt == CNT_W'(N_DELAY));

    if (bus.i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_go) begin
            state_d   = S_CLEAR;
            idx_d     = '0;
            acc_d     = '0;
            run_min_d = CNT_W'(N_DELAY);
            run_max_d = '0;
            run_unf_d = 1'b0;
            run_ovf_d = 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) begin
            state_d = S_FIRE;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        S_FIRE: state_d = S_CAPT;
        S_CAPT: begin
          res_d   = bus.i_result;
          state_d = S_ACC;
        end
        S_ACC: begin
          acc_d     = acc_nxt;
          run_min_d = min_nxt;
          run_max_d = max_nxt;
          run_unf_d = unf_nxt;
          run_ovf_d = ovf_nxt;
          if (idx_q == '1) begin
            state_d = S_DONE;
            sum_d   = acc_nxt;
            min_d   = min_nxt;
            max_d   = max_nxt;
            unf_d   = unf_nxt;
            ovf_d   = ovf_nxt;
          end else begin
            idx_d   = idx_q + LOG_AVG'(1);
            state_d = S_CLEAR;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs decoded from the next state so they leave a flop aligned with the state.
    start_d = (state_d == S_FIRE) || (state_d == S_CAPT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      run_min_q <= '0;
      run_max_q <= '0;
      run_unf_q <= 1'b0;
      run_ovf_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      unf_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      acc_q     <= acc_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      run_unf_q <= run_unf_d;
      run_ovf_q <= run_ovf_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      unf_q     <= unf_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_start    = start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_sum      = sum_q;
  assign bus.o_min      = min_q;
  assign bus.o_max      = max_q;
  assign bus.o_underrun = unf_q;
  assign bus.o_overrun  = ovf_q;
endmodule
